// File: rtl/ifu_fetch.sv
// ifu_fetch: PC owner, in-order imem req/gnt+rvalid fetch, buffered inst/instaddr toward IF/ID (optional IFU_STAT_EN counters).
// Latency: first request the cycle after reset release; accepted rvalid reaches inst_valid_o one cycle later.
// Backpressure: hold_i freezes the head; requests stop once outstanding+buffered reaches DEPTH.
`timescale 1ns/1ps

`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

// ifu_fifo: generic circular FIFO with synchronous flush; head is combinational.
// Latency: push visible at head the cycle after; caller guarantees no push when full or pop when empty.
// Backpressure: none internally, occupancy exposed through count.
module ifu_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             push_vld,
    input  logic [W-1:0]     push_dat,
    input  logic             pop_rdy,
    output logic [W-1:0]     head_dat,
    output logic [CNT_W-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop_rdy)  rd_ptr <= rd_ptr + 1'b1;
            if (push_vld && !pop_rdy)      count <= count + 1'b1;
            else if (!push_vld && pop_rdy) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld && !flush) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter int          CNT_W    = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] instaddr_o,
    output logic        inst_valid_o,
    output logic        lden_o
`ifdef IFU_STAT_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] bubble_cnt_o
`endif
);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

    logic [31:0]      pc;
    logic             started;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] inst_cnt;
    logic [CNT_W:0]   credit_used;
    logic [31:0]      rsp_addr;
    logic [63:0]      head_dat;
    logic             gnt_acc;
    logic             push_vld;
    logic             pop_rdy;
    logic             unused_jump_lsb;

    assign unused_jump_lsb = ^jump_addr_i[1:0];

    // Outstanding count doubles as the issued-address queue occupancy: one entry per grant, one retired per rvalid.
    assign credit_used = {1'b0, outstanding} + {1'b0, inst_cnt};
    assign imem_req_o  = started && (credit_used < DEPTH_C) && !jump_en_i;
    assign imem_addr_o = pc;
    assign gnt_acc     = imem_req_o && imem_gnt_i;

    assign inst_valid_o = (inst_cnt != '0);
    assign push_vld     = imem_rvalid_i && (discard == '0) && !jump_en_i;
    assign pop_rdy      = inst_valid_o && !hold_i && !jump_en_i;
    assign lden_o       = !hold_i;

    assign inst_o     = inst_valid_o ? head_dat[31:0]  : `INST_NOP;
    assign instaddr_o = inst_valid_o ? head_dat[63:32] : 32'h0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc      <= RESET_PC;
            started <= 1'b0;
            discard <= '0;
        end else begin
            started <= 1'b1;
            if (jump_en_i)    pc <= {jump_addr_i[31:2], 2'b00};
            else if (gnt_acc) pc <= pc + 32'd4;
            // Everything still in flight at a redirect belongs to the old stream, except a response retiring now.
            if (jump_en_i)
                discard <= outstanding - {{(CNT_W-1){1'b0}}, imem_rvalid_i};
            else if (imem_rvalid_i && (discard != '0))
                discard <= discard - 1'b1;
        end
    end

    ifu_fifo #(.W(32), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_addr_q (
        .clk      (clk),
        .rstn     (rstn),
        .flush    (1'b0),
        .push_vld (gnt_acc),
        .push_dat (pc),
        .pop_rdy  (imem_rvalid_i),
        .head_dat (rsp_addr),
        .count    (outstanding)
    );

    ifu_fifo #(.W(64), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_inst_q (
        .clk      (clk),
        .rstn     (rstn),
        .flush    (jump_en_i),
        .push_vld (push_vld),
        .push_dat ({rsp_addr, imem_rdata_i}),
        .pop_rdy  (pop_rdy),
        .head_dat (head_dat),
        .count    (inst_cnt)
    );

`ifdef IFU_STAT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_cnt_o  <= 32'h0;
            bubble_cnt_o <= 32'h0;
        end else begin
            if (pop_rdy)                  fetch_cnt_o  <= fetch_cnt_o + 32'd1;
            if (!inst_valid_o && !hold_i) bubble_cnt_o <= bubble_cnt_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: drives ifu_fetch with a modelled in-order memory and checks the delivered stream against
// a reference of consecutive addresses restarted at reset and at every redirect target.
`timescale 1ns/1ps

module tb_ifu_fetch;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = 32'h0;
    logic        hold_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic [31:0] inst_o;
    logic [31:0] instaddr_o;
    logic        inst_valid_o;
    logic        lden_o;
`ifdef IFU_STAT_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] bubble_cnt_o;
`endif

    ifu_fetch #(.RESET_PC(32'h0), .DEPTH(DEPTH), .CNT_W(3)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .jump_en_i     (jump_en_i),
        .jump_addr_i   (jump_addr_i),
        .hold_i        (hold_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_o        (inst_o),
        .instaddr_o    (instaddr_o),
        .inst_valid_o  (inst_valid_o),
        .lden_o        (lden_o)
`ifdef IFU_STAT_EN
        ,
        .fetch_cnt_o   (fetch_cnt_o),
        .bubble_cnt_o  (bubble_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          ready;
    } pend_t;

    typedef struct {
        logic [31:0] ja;
        logic [31:0] fetch;
        logic [31:0] first;
        logic [31:0] second;
    } jvec_t;

    pend_t pend[$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int gnt_pct  = 100;
    int lat_min  = 1;
    int lat_max  = 1;
    logic [31:0] exp_pc, exp_next;
    int m_pops, m_bubbles;
    logic s_req, s_valid;
    logic [31:0] s_addr, s_iaddr, s_inst;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        pend.delete();
        exp_pc    = 32'h0;
        exp_next  = 32'h0;
        m_pops    = 0;
        m_bubbles = 0;
    endtask

    // One clock: drive at posedge+1, check at negedge, advance the reference, return at next posedge+1.
    task automatic cycle(input logic hold, input logic jmp, input logic [31:0] ja);
        int lat;
        logic rv;
        hold_i      = hold;
        jump_en_i   = jmp;
        jump_addr_i = ja;
        imem_gnt_i  = ($urandom_range(99, 0) < gnt_pct);
        rv = (pend.size() > 0) && (pend[0].ready <= cyc);
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? mem_word(pend[0].addr) : $urandom;
        @(negedge clk);
        s_req   = imem_req_o;
        s_addr  = imem_addr_o;
        s_valid = inst_valid_o;
        s_iaddr = instaddr_o;
        s_inst  = inst_o;
        check("lden", lden_o, !hold);
        if (jmp) check("req_on_jump", s_req, 1'b0);
        if (pend.size() >= DEPTH) check("req_credit", s_req, 1'b0);
        if (s_req) check("fetch_addr", s_addr, exp_pc);
        if (s_valid) begin
            check("head_addr", s_iaddr, exp_next);
            check("head_inst", s_inst, mem_word(s_iaddr));
        end else begin
            check("empty_inst", s_inst, NOP);
            check("empty_addr", s_iaddr, 32'h0);
        end
`ifdef IFU_STAT_EN
        check("fetch_cnt", fetch_cnt_o, m_pops);
        check("bubble_cnt", bubble_cnt_o, m_bubbles);
`endif
        if (rv) pend.delete(0);
        if (s_req && imem_gnt_i) begin
            lat = int'($urandom_range(lat_max, lat_min));
            pend.push_back('{addr: s_addr, ready: cyc + lat});
            exp_pc = exp_pc + 32'd4;
        end
        if (!s_valid && !hold) m_bubbles++;
        if (jmp) begin
            exp_pc   = {ja[31:2], 2'b00};
            exp_next = exp_pc;
        end else if (s_valid && !hold) begin
            exp_next = exp_next + 32'd4;
            m_pops++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            if (s_valid) return;
        end
        check({name, "_timeout"}, 32'h0, 32'h1);
    endtask

    jvec_t jt[4];

    initial begin
        int p0;
        jt[0] = '{ja: 32'h0000_0203, fetch: 32'h0000_0200, first: 32'h0000_0200, second: 32'h0000_0204};
        jt[1] = '{ja: 32'hFFFF_FFFE, fetch: 32'hFFFF_FFFC, first: 32'hFFFF_FFFC, second: 32'h0000_0000};
        jt[2] = '{ja: 32'h0000_0101, fetch: 32'h0000_0100, first: 32'h0000_0100, second: 32'h0000_0104};
        jt[3] = '{ja: 32'h7FFF_FFFF, fetch: 32'h7FFF_FFFC, first: 32'h7FFF_FFFC, second: 32'h8000_0000};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", imem_req_o, 1'b0);
        check("rst_valid", inst_valid_o, 1'b0);
        check("rst_inst", inst_o, NOP);
        check("rst_iaddr", instaddr_o, 32'h0);

        // Zero-wait streaming from reset.
        rstn = 1'b1;
        cycle(1'b0, 1'b0, 32'h0);
        check("no_req_release_cycle", s_req, 1'b0);
        cycle(1'b0, 1'b0, 32'h0);
        check("first_req", s_req, 1'b1);
        check("first_addr", s_addr, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        check("second_addr", s_addr, 32'h4);
        check("not_valid_yet", s_valid, 1'b0);
        cycle(1'b0, 1'b0, 32'h0);
        check("first_valid", s_valid, 1'b1);
        check("iaddr0", s_iaddr, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        check("iaddr4", s_iaddr, 32'h4);
        cycle(1'b0, 1'b0, 32'h0);
        check("iaddr8", s_iaddr, 32'h8);
        check("stream_valid", s_valid, 1'b1);

        // Hold for 10 cycles: head frozen, requests drain the credits.
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'h0);
        check("hold_req_dropped", s_req, 1'b0);
        check("hold_head_valid", s_valid, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'h0);

        // Latency 3, redirect with two responses in flight.
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 50 && pend.size() != 2; i++) cycle(1'b0, 1'b0, 32'h0);
        check("two_outstanding", pend.size(), 2);
        cycle(1'b0, 1'b1, 32'h100);
        wait_valid("jump100");
        check("jump100_first", s_iaddr, 32'h100);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0);

        // Redirect coincident with an accepted response and a pop.
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 50; i++) begin
            if (inst_valid_o && pend.size() >= 2 && pend[0].ready <= cyc) break;
            cycle(1'b0, 1'b0, 32'h0);
        end
        cycle(1'b0, 1'b1, 32'h400);
        check("coinc_pop", s_valid, 1'b1);
        cycle(1'b0, 1'b0, 32'h0);
        check("coinc_flushed", s_valid, 1'b0);
        wait_valid("coinc");
        check("coinc_first", s_iaddr, 32'h400);

        // Redirect target alignment and address wrap.
        for (int v = 0; v < 4; v++) begin
            lat_min = 1; lat_max = 2;
            cycle(1'b0, 1'b1, jt[v].ja);
            cycle(1'b0, 1'b0, 32'h0);
            check("jt_req", s_req, 1'b1);
            check("jt_fetch", s_addr, jt[v].fetch);
            check("jt_flushed", s_valid, 1'b0);
            wait_valid("jt_first");
            check("jt_first", s_iaddr, jt[v].first);
            wait_valid("jt_second");
            check("jt_second", s_iaddr, jt[v].second);
        end

        // Randomized traffic: grant stalls, variable latency, holds and redirects.
        gnt_pct = 60; lat_min = 1; lat_max = 4;
        p0 = m_pops;
        for (int i = 0; i < 3000; i++) begin
            logic h, j;
            h = ($urandom_range(99, 0) < 25);
            j = ($urandom_range(99, 0) < 3);
            cycle(h, j, $urandom);
        end
        check("random_progress", (m_pops - p0) > 100, 1'b1);

        // Reset pulse with entries buffered.
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        hold_i = 1'b0;
        jump_en_i = 1'b0;
        imem_rvalid_i = 1'b0;
        rstn = 1'b0;
        #1;
        check("pulse_valid", inst_valid_o, 1'b0);
        check("pulse_inst", inst_o, NOP);
        check("pulse_iaddr", instaddr_o, 32'h0);
        check("pulse_req", imem_req_o, 1'b0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
        cycle(1'b0, 1'b0, 32'h0);
        check("pulse_no_req", s_req, 1'b0);
        cycle(1'b0, 1'b0, 32'h0);
        check("pulse_restart", s_addr, 32'h0);
        wait_valid("pulse");
        check("pulse_first", s_iaddr, 32'h0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit driving the IF/ID pipeline register.
- Owns the PC and issues in-order requests to instruction memory over a req/gnt + rvalid interface.
- Buffers returned words with their addresses in a small FIFO and presents them as inst/instaddr with a load-enable toward IF/ID.
- Handles pipeline hold and jump redirects, including discarding stale in-flight responses.

Parameters:
RESET_PC  32'h0000_0000  PC value after reset; first fetch address
DEPTH  4  instruction FIFO entries (power of two, >=2); also caps outstanding+buffered fetches
CNT_W  3  width of outstanding/discard counters; must hold DEPTH

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous active-low reset
jump_en_i  input  1  redirect request from EX
jump_addr_i  input  32  redirect target
hold_i  input  1  downstream stall; IF/ID must not load
imem_req_o  output  1  fetch request
imem_addr_o  output  32  fetch address (word aligned)
imem_gnt_i  input  1  request accepted when imem_req_o&&imem_gnt_i
imem_rvalid_i  input  1  response valid; responses in request order, >=1 cycle after grant
imem_rdata_i  input  32  response instruction word
inst_o  output  32  instruction to IF/ID
instaddr_o  output  32  address of inst_o
inst_valid_o  output  1  inst_o/instaddr_o hold a real instruction
lden_o  output  1  IF/ID load enable = !hold_i

Behaviour:
- Reset (async, rstn=0): pc=RESET_PC, FIFO empty, outstanding=0, discard=0, imem_req_o=0, inst_valid_o=0, inst_o=`INST_NOP (32'h0000_0013), instaddr_o=0. Counters cleared immediately; reset asserted mid-transaction drops all in-flight state; responses arriving after release with discard=0 are not expected (memory resets together).
- imem_addr_o = pc. imem_req_o = (outstanding + fifo_count < DEPTH) && !jump_en_i; first request is the cycle after rstn deasserts.
- Grant: pc<=pc+4 (wraps modulo 2^32), outstanding+1.
- Response: outstanding-1. If discard>0: discard-1, data dropped. Otherwise push {addr,data}; addr comes from an internal address queue of issued PCs (in order).
- Push is registered: inst_valid_o rises the cycle after the accepted rvalid. No rvalid-to-output bypass.
- Output = FIFO head; inst_o=`INST_NOP and instaddr_o=0 when empty.
- Pop when inst_valid_o && !hold_i (IF/ID captures on that same edge).
- Simultaneous push/pop: count unchanged. Push to a full FIFO cannot occur (credit rule).
- Zero-wait memory: sustained 1 instruction/cycle with DEPTH>=3.
- hold_i=1: head held stable, no pop. Fetching continues until credits are exhausted, then imem_req_o drops.
- jump_en_i=1, for one cycle:
  - pc<={jump_addr_i[31:2],2'b00}; imem_req_o forced 0 that cycle.
  - FIFO flushed (count=0, inst_valid_o=0 next cycle).
  - discard <= outstanding + (rvalid accepted this cycle ? -1 : 0).
  - jump_en_i takes priority over a same-cycle pop/push.
  - Requests resume the next cycle from the target; the first valid instruction is the target instruction.
- jump_en_i while discard>0: discard is recomputed from the current outstanding count (old discards included).
- lden_o is combinational from hold_i, independent of inst_valid_o. IF/ID loads NOP when the FIFO is empty.

Optional Feature:
Macro IFU_STAT_EN.
- Defined: adds outputs fetch_cnt_o[31:0] and bubble_cnt_o[31:0], both reset to 0.
  - fetch_cnt_o increments on each pop.
  - bubble_cnt_o increments each cycle with !inst_valid_o && !hold_i && rstn.
  - Both wrap at 2^32; a jump does not clear them.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset release, RESET_PC=0, zero-wait memory (gnt=1, rvalid next cycle) -> imem_addr_o 0,4,8,... on consecutive cycles; inst_valid_o first high 2 cycles after first req; instaddr_o 0,4,8 one per cycle.
- hold_i=1 for 10 cycles during streaming -> inst_o/instaddr_o frozen; imem_req_o drops once outstanding+count=4; after release, no address skipped or duplicated.
- Memory latency 3 cycles; jump_en_i to 0x100 with 2 outstanding -> both late responses dropped; first valid instaddr_o=0x100; no stale address ever visible.
- jump_addr_i=0x203 -> fetch address 0x200, instaddr_o 0x200.
- jump_en_i coincident with rvalid and pop -> FIFO empty next cycle; discard = outstanding-1; next delivered address = target.
- rstn pulsed low mid-stream with 3 entries buffered -> outputs immediately NOP/0/invalid; fetch restarts at RESET_PC. With IFU_STAT_EN, fetch_cnt_o equals number of pops, and bubble_cnt_o counts the empty cycles after the jump.
